// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared constants, state type and lane-select helper for the 32-lane
// scatter/collect block and its select decoder.
//   LANES   : number of lanes in a packed vector (32)
//   SEL_W   : width of the lane select (5)
//   state_e : collector FSM states (FILL gathers words, HOLD presents vector)
//   lane_of : reversed lane mapping, lane = 31 - sel
// ---------------------------------------------------------------------------
package demux_pkg;

  localparam int unsigned LANES = 32;
  localparam int unsigned SEL_W = 5;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  // For a 5-bit select, bitwise inversion is exactly 31 - sel.
  function automatic logic [SEL_W-1:0] lane_of(input logic [SEL_W-1:0] sel);
    return ~sel;
  endfunction

endpackage

// File: rtl/demux32_collect_dec.sv
// ---------------------------------------------------------------------------
// onehot_dec32
// Combinational 5-bit select to 32-bit one-hot lane write enable, using the
// reversed lane mapping (sel 31 -> bit 0, sel 0 -> bit 31).
//   sel    : lane select, reversed encoding
//   en     : decoder enable; all outputs low when clear
//   onehot : one-hot lane write enable
// ---------------------------------------------------------------------------
module onehot_dec32
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [LANES-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[lane_of(sel)] = 1'b1;
    end
  end

endmodule

// File: rtl/demux32_collect.sv
// ---------------------------------------------------------------------------
// demux32_collect
// Scatters a stream of lane-tagged words into 32 lane registers and presents
// the packed vector downstream under a valid/ready handshake.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : input word valid
//   in_ready   : block accepts a word this cycle (FILL and not in reset)
//   in_data    : word to scatter
//   in_sel     : lane select, lane = 31 - in_sel
//   in_last    : final word of the current vector
//   out_valid  : packed vector available (HOLD)
//   out_ready  : downstream accepts the vector
//   out_data   : packed lanes, lane k at out_data[WIDTH*k +: WIDTH]
//   out_mask   : bit k set when lane k was written in this vector
//   dup_err    : one-cycle pulse after an accept that rewrote a lane
// ---------------------------------------------------------------------------
module demux32_collect
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*LANES-1:0] out_data,
  output logic [LANES-1:0]       out_mask,
  output logic                   dup_err
);

  state_e           state_q, state_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] lane_q [LANES];
  logic [WIDTH-1:0] lane_d [LANES];
  logic             dup_q, dup_d;

  logic             accept;
  logic [LANES-1:0] lane_we;

  // in_ready is gated by rst so nothing is taken on a reset edge.
  always_comb begin
    in_ready  = (state_q == FILL) && !rst;
    out_valid = (state_q == HOLD);
    accept    = in_valid && in_ready;
  end

  onehot_dec32 u_dec (
    .sel    (in_sel),
    .en     (accept),
    .onehot (lane_we)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    lane_d  = lane_q;
    dup_d   = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          mask_d = mask_q | lane_we;
          dup_d  = |(mask_q & lane_we);
          for (int unsigned k = 0; k < LANES; k++) begin
            if (lane_we[k]) begin
              lane_d[k] = in_data;
            end
          end
          // Complete on in_last, or once every lane has been written.
          if (in_last || (&mask_d)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // Clearing lanes on release keeps unwritten lanes of the next
        // vector reading as zero.
        if (out_ready) begin
          state_d = FILL;
          mask_d  = '0;
          for (int unsigned k = 0; k < LANES; k++) begin
            lane_d[k] = '0;
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      mask_q  <= '0;
      dup_q   <= 1'b0;
      for (int unsigned k = 0; k < LANES; k++) begin
        lane_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      dup_q   <= dup_d;
      for (int unsigned k = 0; k < LANES; k++) begin
        lane_q[k] <= lane_d[k];
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      out_data[WIDTH*k +: WIDTH] = lane_q[k];
    end
    out_mask = mask_q;
    dup_err  = dup_q;
  end

endmodule

// File: tb/tb_demux32_collect.sv
module tb_demux32_collect;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned VW    = WIDTH * 32;
  localparam int NWORDS         = 10000;
  localparam int MAXCYC         = 60000;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [4:0]        in_sel;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [VW-1:0]     out_data;
  logic [31:0]       out_mask;
  logic              dup_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux32_collect #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mask  (out_mask),
    .dup_err   (dup_err)
  );

  typedef struct {
    logic [4:0]       sel;
    logic [WIDTH-1:0] data;
    logic             last;
    logic [31:0]      mask;
    logic             dup;
    logic             valid;
  } row_t;

  row_t             rows [5];
  logic [WIDTH-1:0] exp_l [32];
  logic [WIDTH-1:0] m_l   [32];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic checkv(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack(input logic [WIDTH-1:0] l [32]);
    logic [VW-1:0] p;
    p = '0;
    for (int k = 0; k < 32; k++) p[WIDTH*k +: WIDTH] = l[k];
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] sel, input logic [WIDTH-1:0] data, input logic last);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic release_vec();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic clear_exp();
    for (int k = 0; k < 32; k++) exp_l[k] = '0;
  endtask

  initial begin
    logic dup_seen;
    int   words;
    int   cyc;
    logic acc;
    logic m_fill;
    logic m_dup;
    logic [31:0] m_mask;
    int   idx;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; in_last = 1'b0; out_ready = 1'b0;
    clear_exp();

    // ---- reset state
    tick(); tick();
    check1 ("rst_in_ready", in_ready, 1'b0);
    check1 ("rst_out_valid", out_valid, 1'b0);
    check32("rst_out_mask", out_mask, 32'h0);
    check1 ("rst_dup_err", dup_err, 1'b0);
    checkv ("rst_out_data", out_data, '0);
    rst = 1'b0;
    tick();
    check1("post_rst_in_ready", in_ready, 1'b1);

    // ---- 32 accepts, auto-complete without in_last
    dup_seen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      send(5'(31 - i), WIDTH'(32'h0100 + i), 1'b0);
      exp_l[i] = WIDTH'(32'h0100 + i);
      if (dup_err) dup_seen = 1'b1;
      if (i == 30) check1("auto_not_early", out_valid, 1'b0);
    end
    check1 ("auto_out_valid", out_valid, 1'b1);
    check1 ("auto_in_ready", in_ready, 1'b0);
    check32("auto_out_mask", out_mask, 32'hFFFF_FFFF);
    checkv ("auto_out_data", out_data, pack(exp_l));
    tick();
    if (dup_err) dup_seen = 1'b1;
    check1("auto_no_dup", dup_seen, 1'b0);
    release_vec();
    check1 ("rel_in_ready", in_ready, 1'b1);
    check1 ("rel_out_valid", out_valid, 1'b0);
    check32("rel_out_mask", out_mask, 32'h0);
    checkv ("rel_out_data", out_data, '0);
    clear_exp();

    // ---- table of short vectors: edge lanes, duplicate, single-word vector
    rows[0] = '{5'd31, 16'hAAAA, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
    rows[1] = '{5'd0,  16'h5555, 1'b1, 32'h8000_0001, 1'b0, 1'b1};
    rows[2] = '{5'd3,  16'h1111, 1'b0, 32'h1000_0000, 1'b0, 1'b0};
    rows[3] = '{5'd3,  16'h2222, 1'b1, 32'h1000_0000, 1'b1, 1'b1};
    rows[4] = '{5'd7,  16'h1234, 1'b1, 32'h0100_0000, 1'b0, 1'b1};
    for (int r = 0; r < 5; r++) begin
      send(rows[r].sel, rows[r].data, rows[r].last);
      exp_l[31 - int'(rows[r].sel)] = rows[r].data;
      check32($sformatf("row%0d_mask", r), out_mask, rows[r].mask);
      check1 ($sformatf("row%0d_dup", r), dup_err, rows[r].dup);
      check1 ($sformatf("row%0d_valid", r), out_valid, rows[r].valid);
      if (rows[r].valid) begin
        checkv($sformatf("row%0d_data", r), out_data, pack(exp_l));
        tick();
        check1($sformatf("row%0d_dup_clear", r), dup_err, 1'b0);
        check1($sformatf("row%0d_still_valid", r), out_valid, 1'b1);
        release_vec();
        clear_exp();
      end
    end

    // ---- backpressure in HOLD with in_valid asserted
    send(5'd10, 16'hCAFE, 1'b0);
    send(5'd20, 16'hBEAD, 1'b1);
    exp_l[21] = 16'hCAFE;
    exp_l[11] = 16'hBEAD;
    in_valid = 1'b1; in_sel = 5'd1; in_data = 16'h7777; in_last = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check1 ($sformatf("bp%0d_in_ready", c), in_ready, 1'b0);
      check1 ($sformatf("bp%0d_out_valid", c), out_valid, 1'b1);
      check32($sformatf("bp%0d_mask", c), out_mask, 32'h0020_0800);
      checkv ($sformatf("bp%0d_data", c), out_data, pack(exp_l));
    end
    release_vec();
    check1 ("bp_rel_in_ready", in_ready, 1'b1);
    check32("bp_rel_mask", out_mask, 32'h0);
    tick();
    in_valid = 1'b0;
    check32("bp_next_mask", out_mask, 32'h4000_0000);
    send(5'd2, 16'h0002, 1'b1);
    check32("bp_next_mask2", out_mask, 32'h6000_0000);
    check1 ("bp_next_valid", out_valid, 1'b1);
    release_vec();
    clear_exp();

    // ---- reset mid-FILL, then single word, then reset mid-HOLD
    for (int i = 0; i < 5; i++) send(5'(i), WIDTH'(32'h0F00 + i), 1'b0);
    check32("rf_mask_before", out_mask, 32'hF800_0000);
    rst = 1'b1;
    tick();
    check1 ("rf_in_ready_in_rst", in_ready, 1'b0);
    check32("rf_mask", out_mask, 32'h0);
    check1 ("rf_out_valid", out_valid, 1'b0);
    checkv ("rf_data", out_data, '0);
    rst = 1'b0;
    send(5'd0, 16'hBEEF, 1'b1);
    exp_l[31] = 16'hBEEF;
    check32("rf_single_mask", out_mask, 32'h8000_0000);
    check1 ("rf_single_valid", out_valid, 1'b1);
    checkv ("rf_single_data", out_data, pack(exp_l));
    clear_exp();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check1 ("rh_out_valid", out_valid, 1'b0);
    check32("rh_mask", out_mask, 32'h0);
    checkv ("rh_data", out_data, '0);
    tick();
    check1("rh_in_ready", in_ready, 1'b1);
    check1("rh_still_idle", out_valid, 1'b0);

    // ---- random stream against a vector-level reference model
    m_fill = 1'b1; m_dup = 1'b0; m_mask = '0;
    for (int k = 0; k < 32; k++) m_l[k] = '0;
    words = 0; cyc = 0;
    in_valid = 1'b0; out_ready = 1'b0;
    while (words < NWORDS && cyc < MAXCYC) begin
      @(negedge clk);
      check1 ("rnd_in_ready", in_ready, m_fill);
      check1 ("rnd_out_valid", out_valid, !m_fill);
      check1 ("rnd_dup_err", dup_err, m_dup);
      check32("rnd_out_mask", out_mask, m_mask);
      if (!m_fill) checkv("rnd_out_data", out_data, pack(m_l));

      acc   = m_fill && in_valid;
      m_dup = 1'b0;
      if (acc) begin
        idx = 31 - int'(in_sel);
        if (m_mask[idx]) m_dup = 1'b1;
        m_l[idx]    = in_data;
        m_mask[idx] = 1'b1;
        words++;
        if (in_last || m_mask == 32'hFFFF_FFFF) m_fill = 1'b0;
      end else if (!m_fill && out_ready) begin
        m_fill = 1'b1;
        m_mask = '0;
        for (int k = 0; k < 32; k++) m_l[k] = '0;
      end

      @(posedge clk);
      #1;
      cyc++;
      out_ready = 1'($urandom_range(0, 1));
      // An offered word that was not taken is held unchanged.
      if (!(in_valid && !acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 5'($urandom);
        in_data  = WIDTH'($urandom);
        in_last  = ($urandom_range(0, 7) == 0);
      end
    end
    checks++;
    if (words < NWORDS) begin
      failures++;
      $display("FAIL rnd_budget actual=%0d words required=%0d words", words, NWORDS);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
